register_file_oe: RTL and testbench

//  Multi-entry register file for the MIPS datapath; generalises the single-register load/output-enable cell.

---
 rtl/register_file_oe_pkg.sv | 27 ++
 rtl/register_file_oe_if.sv | 42 ++++
 rtl/register_file_oe_cell.sv | 30 +++
 rtl/register_file_oe.sv | 95 +++++++++
 tb/tb_register_file_oe.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/register_file_oe_pkg.sv
// ---------------------------------------------------------------------------
// register_file_oe_pkg
//   Shared constants for the output-enabled register file:
//     - default geometry (WIDTH / DEPTH / ADDR_W)
//     - REG_ZERO, the hardwired-zero entry index
//     - NUM_RD_PORTS, the number of independent read ports
//   Helper functions used by the top level for address decoding.
// ---------------------------------------------------------------------------
package register_file_oe_pkg;

  localparam int WIDTH_DEF    = 32;
  localparam int DEPTH_DEF    = 32;
  localparam int ADDR_W_DEF   = 5;

  // Entry that always reads as zero and silently ignores writes.
  localparam int REG_ZERO     = 0;

  // Port A is index 0, port B is index 1 in the read-port generate loop.
  localparam int NUM_RD_PORTS = 2;

  // True when DEPTH is a power of two, at least 2, and addressed by
  // exactly addr_w bits, so no out-of-range address can be presented.
  function automatic bit geometry_ok(input int depth, input int addr_w);
    return (depth >= 2) && ((1 << addr_w) == depth);
  endfunction

endpackage : register_file_oe_pkg

// File: rtl/register_file_oe_if.sv
// ---------------------------------------------------------------------------
// register_file_oe_if
//   Bundles the write port and both read-port address/enable pairs of the
//   register file.
//     load      write enable
//     waddr     write address
//     in        write data
//     raddr_a   read address, port A      enable_a  output enable, port A
//     raddr_b   read address, port B      enable_b  output enable, port B
//   The tri-state read data (out_a / out_b) is kept off the interface so it
//   can be wired straight onto a shared bus net at the parent level.
//   Modports: master drives every signal, slave (the register file) samples.
// ---------------------------------------------------------------------------
interface register_file_oe_if
  import register_file_oe_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              load;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  in;

  logic [ADDR_W-1:0] raddr_a;
  logic              enable_a;
  logic [ADDR_W-1:0] raddr_b;
  logic              enable_b;

  modport master (
    output load, waddr, in,
    output raddr_a, enable_a,
    output raddr_b, enable_b
  );

  modport slave (
    input load, waddr, in,
    input raddr_a, enable_a,
    input raddr_b, enable_b
  );

endinterface : register_file_oe_if

// File: rtl/register_file_oe_cell.sv
// ---------------------------------------------------------------------------
// register_file_oe_cell
//   One WIDTH-bit storage register of the register file.
//     clock  rising-edge clock
//     reset  synchronous, active-low clear (has priority over load)
//     load   capture d at the next rising edge
//     d      data in
//     q      stored value
//   Only the top level's write decoder asserts load, so at most one cell
//   captures per cycle.
// ---------------------------------------------------------------------------
module register_file_oe_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule : register_file_oe_cell

// File: rtl/register_file_oe.sv
// ---------------------------------------------------------------------------
// register_file_oe
//   DEPTH x WIDTH register file with one synchronous write port and two
//   combinational read ports, each with its own tri-state output enable.
//     clock   rising-edge clock for all state
//     reset   synchronous, active-low; clears every entry at the edge
//     bus     register_file_oe_if.slave: load/waddr/in, raddr_x/enable_x
//     out_a   read data port A, high-Z while enable_a is low
//     out_b   read data port B, high-Z while enable_b is low
//   Entry 0 is a constant zero rather than a register. A write in flight is
//   forwarded to any read port addressing the same nonzero entry, so a
//   reader sees the new value in the same cycle it is written.
// ---------------------------------------------------------------------------
module register_file_oe
  import register_file_oe_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  register_file_oe_if.slave     bus,
  output wire  logic [WIDTH-1:0] out_a,
  output wire  logic [WIDTH-1:0] out_b
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  // Refuse to elaborate a geometry where an address could fall outside
  // the array or where part of the array is unreachable.
  if (!geometry_ok(DEPTH, ADDR_W)) begin : g_bad_geometry
    $error("register_file_oe: DEPTH must be a power of two >= 2 and equal 2**ADDR_W");
  end

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] mem [DEPTH];

  // A write that will actually land at the next edge: not in reset, load
  // asserted, and not aimed at the hardwired-zero entry. This single term
  // feeds both the write decoder and the read bypass so the two can never
  // disagree about whether a write is happening.
  logic wr_live;
  assign wr_live = reset && bus.load && (bus.waddr != ZERO_ADDR);

  assign mem[REG_ZERO] = '0;

  // Write decoder: one-hot load per cell, entry 0 has no cell.
  logic [DEPTH-1:1] wr_sel;

  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_cell
    assign wr_sel[gi] = wr_live && (bus.waddr == ADDR_W'(gi));

    register_file_oe_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .clock (clock),
      .reset (reset),
      .load  (wr_sel[gi]),
      .d     (bus.in),
      .q     (mem[gi])
    );
  end

  // -------------------------------------------------------------------------
  // Read ports (index 0 = port A, index 1 = port B)
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd
    logic [ADDR_W-1:0] raddr;
    logic [WIDTH-1:0]  rdata;

    assign raddr = (gi == 0) ? bus.raddr_a : bus.raddr_b;

    // Later assignments override earlier ones, so the zero-entry rule is
    // applied last and wins over the bypass, which in turn wins over the
    // stored value.
    always_comb begin
      rdata = mem[raddr];
      if (wr_live && (bus.waddr == raddr)) begin
        rdata = bus.in;
      end
      if (raddr == ZERO_ADDR) begin
        rdata = '0;
      end
    end
  end

  // Tri-state drivers: each port releases its net independently of the
  // other port's enable and of reset.
  assign out_a = bus.enable_a ? g_rd[0].rdata : {WIDTH{1'bz}};
  assign out_b = bus.enable_b ? g_rd[1].rdata : {WIDTH{1'bz}};

endmodule : register_file_oe

// File: tb/tb_register_file_oe.sv
// ---------------------------------------------------------------------------
// tb_register_file_oe
//   Directed vectors for register_file_oe (WIDTH=32, DEPTH=32). Each output
//   net is shared with a bench-side bus-mate that drives BUS_IDLE whenever
//   the DUT's enable is low, so a correctly released (high-Z) port reads
//   back as BUS_IDLE, while a port that keeps driving causes contention.
//   Stimulus pushes expected values into a queue shortly after a rising
//   edge; the monitor pops and compares on the following falling edge.
// ---------------------------------------------------------------------------
module tb_register_file_oe;

  localparam int          W        = 32;
  localparam int          AW       = 5;
  localparam logic [31:0] BUS_IDLE = 32'h5A5A_FFFE;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  register_file_oe_if #(.WIDTH(W), .ADDR_W(AW)) rf_bus ();

  wire [W-1:0] out_a;
  wire [W-1:0] out_b;

  // Bench-side bus-mates take the shared nets whenever the DUT lets go.
  assign out_a = rf_bus.enable_a ? {W{1'bz}} : BUS_IDLE;
  assign out_b = rf_bus.enable_b ? {W{1'bz}} : BUS_IDLE;

  register_file_oe #(
    .WIDTH  (W),
    .DEPTH  (32),
    .ADDR_W (AW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (rf_bus),
    .out_a (out_a),
    .out_b (out_b)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  bit          exp_port [$];   // 0 = out_a, 1 = out_b
  logic [31:0] exp_val  [$];
  string       exp_name [$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic expect_out(input bit port, input logic [31:0] val, input string name);
    exp_port.push_back(port);
    exp_val.push_back(val);
    exp_name.push_back(name);
  endtask

  always @(negedge clock) begin : monitor
    bit          p;
    logic [31:0] e;
    logic [31:0] act;
    string       nm;
    while (exp_val.size() > 0) begin
      p   = exp_port.pop_front();
      e   = exp_val.pop_front();
      nm  = exp_name.pop_front();
      act = p ? out_b : out_a;
      n_checks++;
      if (act === e) begin
        n_pass++;
        $display("ok   %-28s out_%s = %h", nm, p ? "b" : "a", act);
      end else begin
        $display("FAIL %-28s out_%s = %h, expected %h", nm, p ? "b" : "a", act, e);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_wr(input logic ld, input logic [4:0] wa, input logic [31:0] wd);
    rf_bus.load  = ld;
    rf_bus.waddr = wa;
    rf_bus.in    = wd;
  endtask

  task automatic set_rd(input logic [4:0] aa, input logic ea,
                        input logic [4:0] ab, input logic eb);
    rf_bus.raddr_a  = aa;
    rf_bus.enable_a = ea;
    rf_bus.raddr_b  = ab;
    rf_bus.enable_b = eb;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // -------------------------------------------------------------------------
  // Directed vectors
  // -------------------------------------------------------------------------
  initial begin : stimulus
    reset = 1'b0;
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(5'd0, 1'b0, 5'd0, 1'b0);
    cyc();                                   // clearing edge
    reset = 1'b1;

    // 1. Everything reads zero after reset; disabled port is released.
    set_rd(5'd0, 1'b1, 5'd0, 1'b0);
    expect_out(0, 32'h0,    "t1 read 0 after reset");
    expect_out(1, BUS_IDLE, "t1 port b released");
    cyc();
    set_rd(5'd5, 1'b1, 5'd0, 1'b0);
    expect_out(0, 32'h0,    "t1 read 5 after reset");
    cyc();
    set_rd(5'd31, 1'b1, 5'd0, 1'b0);
    expect_out(0, 32'h0,    "t1 read 31 after reset");
    cyc();
    set_rd(5'd5, 1'b0, 5'd0, 1'b0);
    expect_out(0, BUS_IDLE, "t1 port a released");
    cyc();

    // 2. Write 5, visible in the write cycle and on both ports afterwards.
    set_wr(1'b1, 5'd5, 32'hA5A5_0001);
    set_rd(5'd5, 1'b1, 5'd0, 1'b0);
    expect_out(0, 32'hA5A5_0001, "t2 bypass on write");
    cyc();
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(5'd5, 1'b1, 5'd5, 1'b1);
    expect_out(0, 32'hA5A5_0001, "t2 stored a");
    expect_out(1, 32'hA5A5_0001, "t2 stored b");
    cyc();

    // 3. Writes to entry 0 are dropped and never bypassed.
    set_wr(1'b1, 5'd0, 32'hFFFF_FFFF);
    set_rd(5'd0, 1'b1, 5'd0, 1'b1);
    expect_out(0, 32'h0, "t3 no bypass to 0 a");
    expect_out(1, 32'h0, "t3 no bypass to 0 b");
    cyc();
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(5'd0, 1'b1, 5'd5, 1'b1);
    expect_out(0, 32'h0,         "t3 entry 0 stays 0");
    expect_out(1, 32'hA5A5_0001, "t3 entry 5 untouched");
    cyc();

    // 4. Bypass over an older stored value.
    set_wr(1'b1, 5'd7, 32'h0000_1111);
    set_rd(5'd0, 1'b0, 5'd0, 1'b0);
    cyc();
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(5'd7, 1'b1, 5'd0, 1'b0);
    expect_out(0, 32'h0000_1111, "t4 old value");
    cyc();
    set_wr(1'b1, 5'd7, 32'h0000_2222);
    set_rd(5'd7, 1'b1, 5'd0, 1'b0);
    expect_out(0, 32'h0000_2222, "t4 bypass before edge");
    cyc();
    set_wr(1'b1, 5'd8, 32'h0000_8888);      // write elsewhere: no bypass on 7
    set_rd(5'd7, 1'b1, 5'd7, 1'b1);
    expect_out(0, 32'h0000_2222, "t4 stored after edge a");
    expect_out(1, 32'h0000_2222, "t4 stored after edge b");
    cyc();
    set_wr(1'b1, 5'd7, 32'h0000_3333);
    set_rd(5'd7, 1'b0, 5'd7, 1'b1);
    expect_out(0, BUS_IDLE,      "t4 a released");
    expect_out(1, 32'h0000_3333, "t4 bypass on port b");
    cyc();
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(5'd8, 1'b1, 5'd7, 1'b1);
    expect_out(0, 32'h0000_8888, "t4 entry 8 stored");
    expect_out(1, 32'h0000_3333, "t4 entry 7 stored");
    cyc();

    // Top entry.
    set_wr(1'b1, 5'd31, 32'hDEAD_0031);
    set_rd(5'd0, 1'b0, 5'd31, 1'b1);
    expect_out(1, 32'hDEAD_0031, "top entry bypass");
    cyc();
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(5'd31, 1'b1, 5'd30, 1'b1);
    expect_out(0, 32'hDEAD_0031, "top entry stored");
    expect_out(1, 32'h0,         "entry 30 untouched");
    cyc();

    // 5. Reset in the middle of a write.
    set_wr(1'b1, 5'd9, 32'h0000_0033);
    set_rd(5'd0, 1'b0, 5'd0, 1'b0);
    cyc();
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(5'd9, 1'b1, 5'd0, 1'b0);
    expect_out(0, 32'h0000_0033, "t5 before reset");
    cyc();
    reset = 1'b0;
    set_wr(1'b1, 5'd9, 32'h0000_0044);
    set_rd(5'd9, 1'b1, 5'd7, 1'b0);
    expect_out(0, 32'h0000_0033, "t5 no bypass in reset");
    expect_out(1, BUS_IDLE,      "t5 b released in reset");
    cyc();
    reset = 1'b1;
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(5'd9, 1'b1, 5'd31, 1'b1);
    expect_out(0, 32'h0, "t5 entry 9 cleared");
    expect_out(1, 32'h0, "t5 entry 31 cleared");
    cyc();
    set_rd(5'd5, 1'b1, 5'd7, 1'b1);
    expect_out(0, 32'h0, "t5 entry 5 cleared");
    expect_out(1, 32'h0, "t5 entry 7 cleared");
    cyc();

    // 6. Port independence.
    set_wr(1'b1, 5'd5, 32'hA5A5_0001);
    set_rd(5'd0, 1'b0, 5'd0, 1'b0);
    cyc();
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(5'd5, 1'b1, 5'd5, 1'b0);
    expect_out(0, 32'hA5A5_0001, "t6 a on b off: a");
    expect_out(1, BUS_IDLE,      "t6 a on b off: b");
    cyc();
    set_rd(5'd5, 1'b0, 5'd5, 1'b1);
    expect_out(0, BUS_IDLE,      "t6 a off b on: a");
    expect_out(1, 32'hA5A5_0001, "t6 a off b on: b");
    cyc();

    // Drain: every queued expectation must have been consumed.
    set_rd(5'd0, 1'b0, 5'd0, 1'b0);
    cyc();
    cyc();
    if (exp_val.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard drain: %0d expectations left, expected 0", exp_val.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_register_file_oe
